// File: rtl/axi4lite_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_fifo_slave
// Purpose  : AXI4-Lite slave in front of the NIC transmit and receive FIFOs.
//            A write pushes {awaddr, wdata} into the TX FIFO. A read pops one
//            word from the RX FIFO, or returns {full, empty} when the read
//            address is STATUS_ADDR. If the TX FIFO is full or the RX FIFO is
//            empty, the transaction gets a SLVERR response and no strobe.
// Ports    : aclk / reset      - clock, synchronous active-high reset
//            aw*, w*, b*       - AXI4-Lite write address / data / response
//            ar*, r*           - AXI4-Lite read address / data
//            write_en/_data    - TX FIFO push strobe and word {aw_q, w_q}
//            full              - TX FIFO full
//            read_en/read_data - RX FIFO pop strobe and FWFT head word
//            empty             - RX FIFO empty
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_fifo_slave #(
    parameter int                 ADDR_W      = 32,
    parameter int                 DATA_W      = 32,
    parameter logic [ADDR_W-1:0]  STATUS_ADDR = {ADDR_W{1'b1}}
) (
    input  logic                       aclk,
    input  logic                       reset,
    // write address channel
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    // write data channel
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       wvalid,
    output logic                       wready,
    // write response channel
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    // read address channel
    input  logic [ADDR_W-1:0]          araddr,
    input  logic                       arvalid,
    output logic                       arready,
    // read data channel
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    // TX FIFO
    output logic                       write_en,
    output logic [ADDR_W+DATA_W-1:0]   write_data,
    input  logic                       full,
    // RX FIFO
    output logic                       read_en,
    input  logic [DATA_W-1:0]          read_data,
    input  logic                       empty
);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // Skid registers: one per request channel
    logic [ADDR_W-1:0] r_aw_q;
    logic              r_aw_held;
    logic [DATA_W-1:0] r_w_q;
    logic              r_w_held;
    logic [ADDR_W-1:0] r_ar_q;
    logic              r_ar_held;

    // Response registers
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_rvalid;
    logic [1:0]        r_rresp;
    logic [DATA_W-1:0] r_rdata;

    logic              w_wr_issue;
    logic              w_rd_issue;
    logic              w_is_status;
    logic [DATA_W-1:0] w_status_word;

    // A request may issue when its response slot is free or is retiring in
    // this same cycle. The new response then replaces the old one without a
    // bubble.
    assign w_wr_issue  = !reset && r_aw_held && r_w_held && (!r_bvalid || bready);
    assign w_rd_issue  = !reset && r_ar_held && (!r_rvalid || rready);
    assign w_is_status = (r_ar_q == STATUS_ADDR);

    // Built bitwise so that DATA_W == 2 needs no zero-width replication
    always_comb begin
        w_status_word      = '0;
        w_status_word[1:0] = {full, empty};
    end

    assign awready    = !reset && !r_aw_held;
    assign wready     = !reset && !r_w_held;
    assign arready    = !reset && !r_ar_held;

    // full/empty are looked at only in the issue cycle
    assign write_en   = w_wr_issue && !full;
    assign write_data = {r_aw_q, r_w_q};
    assign read_en    = w_rd_issue && !w_is_status && !empty;

    assign bvalid     = r_bvalid;
    assign bresp      = r_bresp;
    assign rvalid     = r_rvalid;
    assign rresp      = r_rresp;
    assign rdata      = r_rdata;

    // Write path
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_aw_q    <= '0;
            r_aw_held <= 1'b0;
            r_w_q     <= '0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            // A channel cannot capture while it is held, and it can issue
            // only while held, so capture and clear never collide.
            if (awvalid && awready) begin
                r_aw_q    <= awaddr;
                r_aw_held <= 1'b1;
            end else if (w_wr_issue) begin
                r_aw_held <= 1'b0;
            end

            if (wvalid && wready) begin
                r_w_q    <= wdata;
                r_w_held <= 1'b1;
            end else if (w_wr_issue) begin
                r_w_held <= 1'b0;
            end

            if (w_wr_issue) begin
                r_bvalid <= 1'b1;
                r_bresp  <= full ? c_RESP_SLVERR : c_RESP_OKAY;
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read path
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_ar_q    <= '0;
            r_ar_held <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            if (arvalid && arready) begin
                r_ar_q    <= araddr;
                r_ar_held <= 1'b1;
            end else if (w_rd_issue) begin
                r_ar_held <= 1'b0;
            end

            if (w_rd_issue) begin
                r_rvalid <= 1'b1;
                if (w_is_status) begin
                    r_rdata <= w_status_word;
                    r_rresp <= c_RESP_OKAY;
                end else if (!empty) begin
                    r_rdata <= read_data;
                    r_rresp <= c_RESP_OKAY;
                end else begin
                    r_rdata <= '0;
                    r_rresp <= c_RESP_SLVERR;
                end
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
